redmule_mem_arbiter: RTL and testbench

- Time-shares the single streamer memory port between the four RedMulE traffic sources: X load, W load, Y load and Z store.
- Sits between the per-operand source/sink FIFOs and the TCDM streamer, beside the controller FSM and scheduler.
- Grants whole bursts. Urgent requests win first (e.g. W starving the engine, Z buffer full); otherwise requesters are served round-robin.
- Data-path muxing is external and is driven by grant_id_o.

---
 rtl/redmule_pkg.sv | 19 +
 rtl/redmule_rr_picker.sv | 49 ++++
 rtl/redmule_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_redmule_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// Shared types and constants for the RedMulE streamer memory arbiter.
package redmule_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BURST = 2'd1,
    ARB_ZERO  = 2'd2
  } arb_state_e;

  // Requester slots on the shared streamer port.
  localparam int unsigned ARB_X = 0;
  localparam int unsigned ARB_W = 1;
  localparam int unsigned ARB_Y = 2;
  localparam int unsigned ARB_Z = 3;

  localparam int unsigned ArbNumReq   = 4;
  localparam int unsigned ArbLenWidth = 16;

endpackage

// File: rtl/redmule_rr_picker.sv
// Combinational winner picker: urgent requests go by lowest index, otherwise
// the first valid requester at or after rr_ptr (with wrap-around) wins.
module redmule_rr_picker #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned IdWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]  valid,
  input  logic [NumReq-1:0]  urgent,
  input  logic [IdWidth-1:0] rr_ptr,
  output logic [NumReq-1:0]  onehot,
  output logic [IdWidth-1:0] index,
  output logic               any
);

  logic [2*NumReq-1:0] valid_dbl;
  logic [NumReq-1:0]   valid_rot;
  logic [NumReq-1:0]   urg_valid;

  assign urg_valid = valid & urgent;
  assign valid_dbl = {valid, valid};
  assign valid_rot = valid_dbl[rr_ptr +: NumReq];

  // Scan downwards so the last hit is the lowest index / nearest to rr_ptr.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (urg_valid[i]) begin
        index = IdWidth'(i);
        any   = 1'b1;
      end
    end
    if (!any) begin
      for (int k = NumReq - 1; k >= 0; k--) begin
        if (valid_rot[k]) begin
          index = IdWidth'((int'(rr_ptr) + k) % NumReq);
          any   = 1'b1;
        end
      end
    end
  end

  // One-hot form of the chosen index.
  always_comb begin
    onehot = '0;
    if (any) onehot[index] = 1'b1;
  end

endmodule

// File: rtl/redmule_mem_arbiter.sv
// Burst-granular arbiter sharing the streamer memory port among X/W/Y/Z.
// Optional per-requester grant counters: define REDMULE_ARB_STATS_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ARB_IDLE  | pick a winner, accept its request, latch id and length
// ARB_BURST | pass beats of the owner until the down-counter hits zero
// ARB_ZERO  | zero-length burst: one busy cycle with burst_done_o
module redmule_mem_arbiter
  import redmule_pkg::*;
#(
  parameter int unsigned NumReq   = ArbNumReq,
  parameter int unsigned LenWidth = ArbLenWidth,
  parameter int unsigned IdWidth  = $clog2(NumReq)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       enable_i,
  input  logic [NumReq-1:0]          req_valid_i,
  input  logic [NumReq*LenWidth-1:0] req_len_i,
  input  logic [NumReq-1:0]          urgent_i,
  output logic [NumReq-1:0]          req_ready_o,
  input  logic [NumReq-1:0]          src_beat_valid_i,
  output logic [NumReq-1:0]          src_beat_ready_o,
  output logic                       mem_valid_o,
  input  logic                       mem_ready_i,
  output logic [IdWidth-1:0]         grant_id_o,
  output logic                       busy_o,
  output logic                       burst_done_o,
  output logic [NumReq*32-1:0]       stats_grants_o
);

  arb_state_e          state_q;
  logic [IdWidth-1:0]  grant_id_q;
  logic [IdWidth-1:0]  rr_ptr_q;
  logic [IdWidth-1:0]  rr_next;
  logic [LenWidth-1:0] cnt_q;
  logic [LenWidth-1:0] win_len;
  logic [NumReq-1:0]   pick_onehot;
  logic [IdWidth-1:0]  pick_idx;
  logic                pick_any;
  logic                grant;
  logic                fire;

  redmule_rr_picker #(
    .NumReq  (NumReq),
    .IdWidth (IdWidth)
  ) i_picker (
    .valid  (req_valid_i),
    .urgent (urgent_i),
    .rr_ptr (rr_ptr_q),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  assign win_len = req_len_i[int'(pick_idx)*LenWidth +: LenWidth];
  assign grant   = (state_q == ARB_IDLE) && enable_i && pick_any && !clear_i;
  assign fire    = (state_q == ARB_BURST) && mem_valid_o && mem_ready_i;
  assign rr_next = IdWidth'((int'(grant_id_q) + 1) % NumReq);

  assign grant_id_o = grant_id_q;
  assign busy_o     = (state_q != ARB_IDLE);

  // Handshake outputs; a clear cycle suppresses every accept and beat.
  always_comb begin
    req_ready_o      = grant ? pick_onehot : '0;
    mem_valid_o      = 1'b0;
    src_beat_ready_o = '0;
    burst_done_o     = 1'b0;
    if (!clear_i) begin
      if (state_q == ARB_BURST) begin
        mem_valid_o                  = src_beat_valid_i[grant_id_q] & enable_i;
        src_beat_ready_o[grant_id_q] = mem_ready_i & enable_i;
        burst_done_o                 = mem_valid_o & mem_ready_i & (cnt_q == LenWidth'(1));
      end else if (state_q == ARB_ZERO) begin
        burst_done_o = 1'b1;
      end
    end
  end

  // Arbitration FSM with burst beat down-counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else if (clear_i) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (grant) begin
            grant_id_q <= pick_idx;
            cnt_q      <= win_len;
            state_q    <= (win_len != '0) ? ARB_BURST : ARB_ZERO;
          end
        end
        ARB_BURST: begin
          if (fire) begin
            if (cnt_q != '0) cnt_q <= cnt_q - LenWidth'(1);
            if (cnt_q == LenWidth'(1)) begin
              rr_ptr_q <= rr_next;
              state_q  <= ARB_IDLE;
            end
          end
        end
        ARB_ZERO: begin
          rr_ptr_q <= rr_next;
          state_q  <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

`ifdef REDMULE_ARB_STATS_EN
  logic [31:0] stats_q [NumReq];

  // Saturating grant counters, one per requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumReq; i++) stats_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NumReq; i++) stats_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (req_ready_o[i] && (stats_q[i] != 32'hFFFF_FFFF)) stats_q[i] <= stats_q[i] + 32'd1;
      end
    end
  end

  // Flatten counters onto the stats bus.
  always_comb begin
    stats_grants_o = '0;
    for (int i = 0; i < NumReq; i++) stats_grants_o[i*32 +: 32] = stats_q[i];
  end
`else
  assign stats_grants_o = '0;
`endif

endmodule

// File: tb/tb_redmule_mem_arbiter.sv
// Self-checking bench for redmule_mem_arbiter: a cycle model checked on every
// falling edge plus directed scenarios with hand-computed expectations.
module tb_redmule_mem_arbiter;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          enable_i;
  logic [3:0]    req_valid_i;
  logic [63:0]   req_len_i;
  logic [3:0]    urgent_i;
  logic [3:0]    req_ready_o;
  logic [3:0]    src_beat_valid_i;
  logic [3:0]    src_beat_ready_o;
  logic          mem_valid_o;
  logic          mem_ready_i;
  logic [1:0]    grant_id_o;
  logic          busy_o;
  logic          burst_done_o;
  logic [127:0]  stats_grants_o;

  int tests = 0;
  int fails = 0;

  redmule_mem_arbiter dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clear_i          (clear_i),
    .enable_i         (enable_i),
    .req_valid_i      (req_valid_i),
    .req_len_i        (req_len_i),
    .urgent_i         (urgent_i),
    .req_ready_o      (req_ready_o),
    .src_beat_valid_i (src_beat_valid_i),
    .src_beat_ready_o (src_beat_ready_o),
    .mem_valid_o      (mem_valid_o),
    .mem_ready_i      (mem_ready_i),
    .grant_id_o       (grant_id_o),
    .busy_o           (busy_o),
    .burst_done_o     (burst_done_o),
    .stats_grants_o   (stats_grants_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return -1;
  endfunction

  // Winner by the arbitration rules: urgent lowest index, else rotate from rr.
  function automatic int pick(input logic [3:0] v, input logic [3:0] u, input int rr);
    for (int i = 0; i < 4; i++) if (v[i] && u[i]) return i;
    for (int k = 0; k < 4; k++) if (v[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  // Reference model: remaining beats of the current burst, pending zero-length
  // burst, owner, rotation pointer and grant tallies.
  int          m_rem = 0;
  bit          m_zero = 1'b0;
  int          m_owner = 0;
  int          m_rr = 0;
  int unsigned m_stats [4] = '{0, 0, 0, 0};

  always @(negedge clk_i) begin : model_cmp
    logic [3:0]   e_req, e_sbr;
    logic         e_mv, e_done, e_busy;
    logic [127:0] e_stats;
    int           w;
    if (!rst_ni) begin
      m_rem = 0; m_zero = 1'b0; m_owner = 0; m_rr = 0;
      for (int i = 0; i < 4; i++) m_stats[i] = 0;
      chk("reset_outputs", {req_ready_o, src_beat_ready_o, mem_valid_o, busy_o, burst_done_o, grant_id_o}, '0);
      chk("reset_stats", stats_grants_o, '0);
    end else begin
      e_req = '0; e_sbr = '0; e_mv = 1'b0; e_done = 1'b0; w = -1;
      e_busy = (m_rem > 0) || m_zero;
      if (m_rem > 0) begin
        if (!clear_i) begin
          e_mv = src_beat_valid_i[m_owner] & enable_i;
          e_sbr[m_owner] = mem_ready_i & enable_i;
          e_done = e_mv & mem_ready_i & (m_rem == 1);
        end
      end else if (m_zero) begin
        e_done = !clear_i;
      end else if (enable_i && (req_valid_i != 0) && !clear_i) begin
        w = pick(req_valid_i, urgent_i, m_rr);
        e_req[w] = 1'b1;
      end
`ifdef REDMULE_ARB_STATS_EN
      for (int i = 0; i < 4; i++) e_stats[i*32 +: 32] = m_stats[i];
`else
      e_stats = '0;
`endif
      chk("m_req_ready", req_ready_o, e_req);
      chk("m_mem_valid", mem_valid_o, e_mv);
      chk("m_src_ready", src_beat_ready_o, e_sbr);
      chk("m_busy", busy_o, e_busy);
      chk("m_done", burst_done_o, e_done);
      chk("m_stats", stats_grants_o, e_stats);
      if (e_busy) chk("m_grant_id", grant_id_o, m_owner);
      // advance the model to the next cycle
      for (int i = 0; i < 4; i++) if (e_req[i] && m_stats[i] != 32'hFFFF_FFFF) m_stats[i]++;
      if (clear_i) begin
        m_rem = 0; m_zero = 1'b0; m_rr = 0;
        for (int i = 0; i < 4; i++) m_stats[i] = 0;
      end else if (m_rem > 0) begin
        if (e_mv && mem_ready_i) begin
          m_rem--;
          if (m_rem == 0) m_rr = (m_owner + 1) % 4;
        end
      end else if (m_zero) begin
        m_zero = 1'b0;
        m_rr = (m_owner + 1) % 4;
      end else if (w >= 0) begin
        m_owner = w;
        m_rem = int'(req_len_i[w*16 +: 16]);
        m_zero = (m_rem == 0);
      end
    end
  end

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (req_ready_o != 0) begin
        idx = oh2idx(req_ready_o);
        step();
        return;
      end
      step();
    end
    tests++; fails++;
    $display("FAIL grant_timeout: got no req_ready_o within 40 cycles, required a grant");
  endtask

  task automatic quiesce();
    int n;
    req_valid_i = '0; urgent_i = '0; enable_i = 1'b1;
    mem_ready_i = 1'b1; src_beat_valid_i = 4'hF;
    n = 0;
    @(negedge clk_i);
    while (busy_o && n < 40) begin
      step();
      @(negedge clk_i);
      n++;
    end
    if (n >= 40) begin
      tests++; fails++;
      $display("FAIL quiesce_timeout: busy_o still %0b, required 0", busy_o);
    end
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [12:0] done_mask;
    logic [3:0]  glog [5];
    int          gcnt, g, beats, done_at;
    logic [6:0]  sbr_vec;
    bit          pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b1;
    req_valid_i = '0; req_len_i = '0; urgent_i = '0;
    src_beat_valid_i = 4'hF; mem_ready_i = 1'b1;
    step(); step();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_grant_id", grant_id_o, 2'd0);
    step();

    // Round-robin: all valid, len 2 each.
    req_len_i = {4{16'd2}};
    req_valid_i = 4'hF;
    done_mask = '0; gcnt = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk_i);
      if (burst_done_o) done_mask[c] = 1'b1;
      if (req_ready_o != 0 && gcnt < 5) begin
        glog[gcnt] = 4'(oh2idx(req_ready_o));
        gcnt++;
      end
      step();
    end
    req_valid_i = '0;
    chk("rr_done_cycles", done_mask, 13'h924);
    chk("rr_grant_count", gcnt, 5);
    chk("rr_grant_order", {glog[0], glog[1], glog[2], glog[3], glog[4]}, 20'h01230);
    quiesce();

    // Urgency: bring rr_ptr to 2 via a burst of requester 1, then urgent W.
    req_len_i = {4{16'd1}};
    req_valid_i = 4'b0010;
    wait_grant(g);
    chk("urg_setup_grant", g, 1);
    req_valid_i = '0;
    step();
    req_valid_i = 4'hF; urgent_i = 4'b0010;
    wait_grant(g);
    chk("urg_first_grant", g, 1);
    req_valid_i = 4'b1101; urgent_i = '0;
    wait_grant(g);
    chk("urg_next_grant", g, 2);
    quiesce();

    // Backpressure: requester 3, len 4.
    req_len_i = '0; req_len_i[63:48] = 16'd4;
    req_valid_i = 4'b1000; mem_ready_i = 1'b0;
    wait_grant(g);
    chk("bp_grant", g, 3);
    req_valid_i = '0;
    beats = 0; done_at = -1; sbr_vec = '0;
    for (int i = 0; i < 7; i++) begin
      mem_ready_i = pat[i];
      @(negedge clk_i);
      sbr_vec[i] = src_beat_ready_o[3];
      if (mem_valid_o && mem_ready_i) beats++;
      if (burst_done_o && done_at < 0) done_at = i;
      step();
    end
    mem_ready_i = 1'b1;
    chk("bp_beats", beats, 4);
    chk("bp_done_cycle", done_at, 6);
    chk("bp_src_ready_mirror", sbr_vec, 7'h59);
    @(negedge clk_i);
    chk("bp_idle_after", busy_o, 1'b0);
    step();
    quiesce();

    // Zero-length burst from requester 0.
    req_len_i = '0;
    req_valid_i = 4'b0001;
    wait_grant(g);
    chk("zero_grant", g, 0);
    req_valid_i = '0;
    @(negedge clk_i);
    chk("zero_busy", busy_o, 1'b1);
    chk("zero_done", burst_done_o, 1'b1);
    chk("zero_no_beat", mem_valid_o, 1'b0);
    step();
    @(negedge clk_i);
    chk("zero_back_idle", busy_o, 1'b0);
    step();
    quiesce();

    // Clear mid-burst: requester 1 len 8, clear after 3 beats.
    req_len_i = '0; req_len_i[31:16] = 16'd8;
    req_valid_i = 4'b0010;
    wait_grant(g);
    chk("clr_grant", g, 1);
    req_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      step();
    end
    clear_i = 1'b1;
    @(negedge clk_i);
    chk("clr_mem_valid", mem_valid_o, 1'b0);
    chk("clr_src_ready", src_beat_ready_o, 4'b0000);
    step();
    clear_i = 1'b0;
    @(negedge clk_i);
    chk("clr_idle", busy_o, 1'b0);
    step();
    req_len_i[47:32] = 16'd1;
    req_valid_i = 4'b0100;
    wait_grant(g);
    chk("clr_new_grant", g, 2);
    req_valid_i = '0;
    @(negedge clk_i);
    chk("clr_new_owner", grant_id_o, 2'd2);
    step();
    quiesce();

    // Stall during a burst: requester 2 len 3, enable low for 2 cycles.
    req_len_i = '0; req_len_i[47:32] = 16'd3;
    req_valid_i = 4'b0100;
    wait_grant(g);
    req_valid_i = '0;
    @(negedge clk_i);
    step();
    enable_i = 1'b0;
    @(negedge clk_i);
    chk("stall_mem_valid", mem_valid_o, 1'b0);
    chk("stall_src_ready", src_beat_ready_o, 4'b0000);
    chk("stall_busy", busy_o, 1'b1);
    step();
    @(negedge clk_i);
    step();
    enable_i = 1'b1;
    @(negedge clk_i);
    chk("stall_resume_not_done", burst_done_o, 1'b0);
    step();
    @(negedge clk_i);
    chk("stall_resume_done", burst_done_o, 1'b1);
    step();
    // Stall while idle: no acceptance.
    enable_i = 1'b0;
    req_len_i = '0; req_len_i[15:0] = 16'd1;
    req_valid_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_idle_no_grant", req_ready_o, 4'b0000);
      step();
    end
    enable_i = 1'b1;
    wait_grant(g);
    chk("stall_idle_then_grant", g, 0);
    quiesce();

    // Grant statistics: five zero-length grants to requester 1.
    req_len_i = '0;
    req_valid_i = 4'b0010;
    for (int k = 0; k < 5; k++) wait_grant(g);
    req_valid_i = '0;
    @(negedge clk_i);
`ifdef REDMULE_ARB_STATS_EN
    chk("stats_w_count", stats_grants_o[63:32], 32'd5);
`else
    chk("stats_disabled", stats_grants_o, '0);
`endif
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    @(negedge clk_i);
    chk("stats_cleared", stats_grants_o[63:32], 32'd0);
    step();

    // Asynchronous reset in the middle of a burst.
    req_len_i = '0; req_len_i[63:48] = 16'd5;
    req_valid_i = 4'b1000;
    wait_grant(g);
    req_valid_i = '0;
    @(negedge clk_i);
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_mem_valid", mem_valid_o, 1'b0);
    chk("arst_grant_id", grant_id_o, 2'd0);
    step(); step();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("arst_idle_after", busy_o, 1'b0);
    step();
    req_len_i[15:0] = 16'd1; req_len_i[47:32] = 16'd1;
    req_valid_i = 4'b0101;
    wait_grant(g);
    chk("arst_rr_restart", g, 0);
    quiesce();

    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
